// File: rtl/lift_car_model.sv
// Cycle-level model of one elevator car and hoist: turns a motor command and a
// door request into registered floor position, door state and arrival pulses.
module lift_car_model #(
    parameter int FLOORS        = 11,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4,
    parameter int RESET_FLOOR   = 0,
    localparam int FW = $clog2(FLOORS),
    localparam int CW = $clog2(TRAVEL_CYCLES),
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        motor_signal,
    input  logic              door_req,
    output logic [FW-1:0]     current_floor,
    output logic [FLOORS-1:0] floor_onehot,
    output logic              moving,
    output logic              dir_up,
    output logic              door_open,
    output logic              arrived,
    output logic              fault
);

    localparam logic [1:0] STOPPED   = 2'd0;
    localparam logic [1:0] MOVE_UP   = 2'd1;
    localparam logic [1:0] MOVE_DOWN = 2'd2;
    localparam logic [1:0] DOOR      = 2'd3;

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_UP   = 2'b01;
    localparam logic [1:0] CMD_DOWN = 2'b10;
    localparam logic [1:0] CMD_ILL  = 2'b11;

    localparam logic [FW-1:0] TOP_FLOOR   = FW'(FLOORS - 1);
    localparam logic [FW-1:0] BOOT_FLOOR  = FW'(RESET_FLOOR);
    localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

    logic [1:0]    state;
    logic [CW-1:0] travel_cnt;
    logic [DW-1:0] door_cnt;
    logic          violation;
    logic [FW-1:0] next_floor;
    logic          keep_going;

    // Saturating one-floor step; boundary checks elsewhere keep this from clipping.
    function automatic logic [FW-1:0] step_floor(input logic [FW-1:0] f, input logic up);
        if (up)
            return (f == TOP_FLOOR) ? f : f + 1'b1;
        else
            return (f == '0) ? f : f - 1'b1;
    endfunction

    function automatic logic [FLOORS-1:0] floor_to_onehot(input logic [FW-1:0] f);
        return FLOORS'(1) << f;
    endfunction

    assign next_floor = step_floor(current_floor, state == MOVE_UP);
    assign keep_going = (state == MOVE_UP) ? (motor_signal == CMD_UP   && next_floor != TOP_FLOOR)
                                           : (motor_signal == CMD_DOWN && next_floor != '0);

    always_comb begin
        violation = (motor_signal == CMD_ILL);
        case (state)
            STOPPED: begin
                if (door_req && motor_signal != CMD_STOP)
                    violation = 1'b1;
                else if (!door_req && motor_signal == CMD_UP && current_floor == TOP_FLOOR)
                    violation = 1'b1;
                else if (!door_req && motor_signal == CMD_DOWN && current_floor == '0)
                    violation = 1'b1;
            end
            MOVE_UP:   if (motor_signal == CMD_DOWN) violation = 1'b1;
            MOVE_DOWN: if (motor_signal == CMD_UP)   violation = 1'b1;
            DOOR:      if (motor_signal != CMD_STOP) violation = 1'b1;
            default:   violation = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= STOPPED;
            current_floor <= BOOT_FLOOR;
            floor_onehot  <= floor_to_onehot(BOOT_FLOOR);
            moving        <= 1'b0;
            dir_up        <= 1'b0;
            door_open     <= 1'b0;
            arrived       <= 1'b0;
            fault         <= 1'b0;
            travel_cnt    <= '0;
            door_cnt      <= '0;
        end else begin
            arrived <= 1'b0;
            if (violation)
                fault <= 1'b1;
            case (state)
                STOPPED: begin
                    // The door has priority over any motor command.
                    if (door_req) begin
                        state     <= DOOR;
                        door_cnt  <= DOOR_LOAD;
                        door_open <= 1'b1;
                    end else if (motor_signal == CMD_UP && current_floor != TOP_FLOOR) begin
                        state        <= MOVE_UP;
                        travel_cnt   <= TRAVEL_LOAD;
                        dir_up       <= 1'b1;
                        moving       <= 1'b1;
                        floor_onehot <= '0;
                    end else if (motor_signal == CMD_DOWN && current_floor != '0) begin
                        state        <= MOVE_DOWN;
                        travel_cnt   <= TRAVEL_LOAD;
                        dir_up       <= 1'b0;
                        moving       <= 1'b1;
                        floor_onehot <= '0;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (travel_cnt != '0) begin
                        travel_cnt <= travel_cnt - 1'b1;
                    end else begin
                        arrived       <= 1'b1;
                        current_floor <= next_floor;
                        if (keep_going) begin
                            travel_cnt <= TRAVEL_LOAD;
                        end else begin
                            state        <= STOPPED;
                            moving       <= 1'b0;
                            floor_onehot <= floor_to_onehot(next_floor);
                        end
                    end
                end
                DOOR: begin
                    if (door_cnt != '0) begin
                        door_cnt <= door_cnt - 1'b1;
                    end else if (!door_req) begin
                        state     <= STOPPED;
                        door_open <= 1'b0;
                    end
                end
                default: state <= STOPPED;
            endcase
        end
    end

endmodule
